spi_xfer_arbiter: RTL

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_xfer_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that hands a single SPI engine to one of NUM_REQ
// requesters at a time, launches the transfer, waits for completion (or a
// timeout) and returns the read word.
module spi_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      spi_go,
  output logic [DATA_W-1:0]         spi_wdata,
  input  logic                      spi_pack_ready,
  input  logic [DATA_W-1:0]         spi_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_grant, win_idx, win;
  logic             win_found;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             pr_d;
  logic             cpl;

  // falling edge of pack_ready; pr_d resets low so reset release cannot fake one
  assign cpl = pr_d & ~spi_pack_ready;

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign timeout_err = done & err;
  assign spi_go      = (state == S_LAUNCH);

  // round-robin pick: first pending requester after last_grant, wrapping
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[(int'(last_grant) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win       = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|req) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (cpl || cnt == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // datapath: grant/word latch, timeout counter, read capture, priority pointer.
  // The counter is armed on entry to LAUNCH so it reads TIMEOUT_CYC-1 while
  // spi_go is high; a timeout then lands done exactly TIMEOUT_CYC cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pr_d       <= 1'b0;
      grant      <= '0;
      spi_wdata  <= '0;
      rdata      <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      win_idx    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      pr_d <= spi_pack_ready;
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant     <= NUM_REQ'(1) << win;
            win_idx   <= win;
            spi_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
            cnt       <= CNT_W'(TIMEOUT_CYC - 1);
            err       <= 1'b0;
          end
        end
        S_LAUNCH: cnt <= cnt - 1'b1;
        S_WAIT: begin
          if (cpl)              rdata <= spi_rdata;
          else if (cnt == '0)   err   <= 1'b1;
          else                  cnt   <= cnt - 1'b1;
        end
        S_DONE: begin
          last_grant <= win_idx;
          grant      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
